// File: rtl/dcache_if.sv
// Datapath request and memory port signals of the data cache.
// slave: the cache side; master: the datapath/memory side that drives it.
interface dcache_if;
   logic        halt;
   logic        dmemREN;
   logic        dmemWEN;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore;
   logic        dhit;
   logic [31:0] dmemload;
   logic        flushed;
   logic        dwait;
   logic [31:0] dload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;

   modport slave (
      input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
      output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
   );

   modport master (
      output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
      input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
   );
endinterface

// File: rtl/dcache.sv
// Write-back 2-way set-associative data cache, 8 sets of 2-word blocks.
// Misses evict the LRU way; halt flushes dirty blocks and stores the hit count.
module dcache #(
   parameter logic [31:0] HIT_ADDR = 32'h0000_3100
) (
   input logic     CLK,
   input logic     nRST,
   dcache_if.slave dcif
);
   localparam int unsigned TAG_W  = 26;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned SETS   = 8;
   localparam int unsigned FRAMES = 16;
   localparam int unsigned FR_W   = 4;

   typedef enum logic [3:0] {
      IDLE, WB1, WB2, LD1, LD2, FLUSH1, FLUSH2, CNT, HALT
   } state_t;

   state_t            state, next_state;
   logic [FR_W-1:0]   flush_cnt, next_flush_cnt;
   logic              victim, next_victim;

   logic [FRAMES-1:0] valid, dirty;
   logic [SETS-1:0]   lru;
   logic [TAG_W-1:0]  tag  [FRAMES];
   logic [31:0]       data [FRAMES][2];
   logic              miss_pending;
   logic [31:0]       hit_cnt;

   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic              req_off, req, hit0, hit1;
   logic [FR_W-1:0]   hit_frame, vf;
   logic              miss_entry;
   logic              unused_addr_lsb;

   // Request decode; frames are numbered {set, way}
   assign req_tag   = dcif.dmemaddr[31:6];
   assign req_idx   = dcif.dmemaddr[5:3];
   assign req_off   = dcif.dmemaddr[2];
   assign req       = dcif.dmemREN | dcif.dmemWEN;
   assign hit0      = valid[{req_idx, 1'b0}] && (tag[{req_idx, 1'b0}] == req_tag);
   assign hit1      = valid[{req_idx, 1'b1}] && (tag[{req_idx, 1'b1}] == req_tag);
   assign hit_frame = {req_idx, hit1};
   assign vf        = {req_idx, victim};
   assign unused_addr_lsb = ^dcif.dmemaddr[1:0];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         flush_cnt <= '0;
         victim    <= 1'b0;
      end else begin
         state     <= next_state;
         flush_cnt <= next_flush_cnt;
         victim    <= next_victim;
      end
   end

   always_comb begin
      next_state     = state;
      next_flush_cnt = flush_cnt;
      next_victim    = victim;
      dcif.dhit      = 1'b0;
      dcif.dmemload  = '0;
      dcif.flushed   = 1'b0;
      dcif.dREN      = 1'b0;
      dcif.dWEN      = 1'b0;
      dcif.daddr     = '0;
      dcif.dstore    = '0;
      case (state)
         IDLE: begin
            if (dcif.halt) begin
               next_state     = FLUSH1;
               next_flush_cnt = '0;
            end else if (req) begin
               if (hit0 || hit1) begin
                  dcif.dhit     = 1'b1;
                  dcif.dmemload = data[hit_frame][req_off];
               end else begin
                  next_victim = lru[req_idx];
                  if (valid[{req_idx, lru[req_idx]}] && dirty[{req_idx, lru[req_idx]}])
                     next_state = WB1;
                  else
                     next_state = LD1;
               end
            end
         end
         WB1, WB2: begin
            dcif.dWEN   = 1'b1;
            dcif.daddr  = {tag[vf], req_idx, (state == WB2), 2'b00};
            dcif.dstore = data[vf][state == WB2];
            if (!dcif.dwait) next_state = (state == WB1) ? WB2 : LD1;
         end
         LD1, LD2: begin
            dcif.dREN  = 1'b1;
            dcif.daddr = {req_tag, req_idx, (state == LD2), 2'b00};
            if (!dcif.dwait) next_state = (state == LD1) ? LD2 : IDLE;
         end
         FLUSH1, FLUSH2: begin
            if (valid[flush_cnt] && dirty[flush_cnt]) begin
               dcif.dWEN   = 1'b1;
               dcif.daddr  = {tag[flush_cnt], flush_cnt[3:1], (state == FLUSH2), 2'b00};
               dcif.dstore = data[flush_cnt][state == FLUSH2];
            end
            // Clean frames skip straight on; dirty ones advance per completed word
            if (!dcif.dWEN || !dcif.dwait) begin
               if (state == FLUSH1 && dcif.dWEN) begin
                  next_state = FLUSH2;
               end else if (flush_cnt == FR_W'(FRAMES - 1)) begin
                  next_state = CNT;
               end else begin
                  next_state     = FLUSH1;
                  next_flush_cnt = FR_W'(flush_cnt + FR_W'(1));
               end
            end
         end
         CNT: begin
            dcif.dWEN   = 1'b1;
            dcif.daddr  = HIT_ADDR;
            dcif.dstore = hit_cnt;
            if (!dcif.dwait) next_state = HALT;
         end
         HALT:    dcif.flushed = 1'b1;
         default: next_state = IDLE;
      endcase
   end

   assign miss_entry = (state == IDLE) && ((next_state == WB1) || (next_state == LD1));

   // Control bits and hit statistics
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid        <= '0;
         dirty        <= '0;
         lru          <= '0;
         miss_pending <= 1'b0;
         hit_cnt      <= '0;
      end else begin
         if (dcif.dhit) begin
            lru[req_idx] <= ~hit1;
            if (dcif.dmemWEN) dirty[hit_frame] <= 1'b1;
            if (!miss_pending) hit_cnt <= hit_cnt + 32'd1;
         end
         if (state == LD2 && !dcif.dwait) begin
            valid[vf] <= 1'b1;
            dirty[vf] <= 1'b0;
         end
         if (miss_entry)     miss_pending <= 1'b1;
         else if (dcif.dhit) miss_pending <= 1'b0;
      end
   end

   // Tag and data arrays need no reset; valid bits guard them
   always_ff @(posedge CLK) begin
      if (dcif.dhit && dcif.dmemWEN) data[hit_frame][req_off] <= dcif.dmemstore;
      if (state == LD1 && !dcif.dwait) data[vf][0] <= dcif.dload;
      if (state == LD2 && !dcif.dwait) begin
         data[vf][1] <= dcif.dload;
         tag[vf]     <= req_tag;
      end
   end
endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: table of datapath accesses plus a memory
// scoreboard of expected transfers, with flush and mid-fill reset sequences.
`timescale 1ns/1ps
module tb_dcache;
   localparam logic [31:0] HIT_A = 32'h0000_3100;

   logic CLK = 1'b0;
   logic nRST;
   dcache_if dcif ();

   dcache #(.HIT_ADDR(HIT_A)) dut (.CLK(CLK), .nRST(nRST), .dcif(dcif));

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } mtx_t;

   typedef struct packed {
      logic        chk;
      logic [31:0] val;
   } ld_t;

   typedef struct packed {
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_load;
      logic        wb;
      logic [31:0] wb_addr;
      logic [31:0] wb_d0;
      logic [31:0] wb_d1;
      logic        fill;
   } vec_t;

   mtx_t mem_q[$];
   ld_t  ld_q[$];
   int   checks = 0;
   int   errors = 0;
   int   lat    = 2;
   int   wait_cnt = 0;

   logic [31:0] mem     [16384];
   bit          written [16384];

   function automatic logic [31:0] init_word(input logic [31:0] a);
      if (a == 32'h100) return 32'h0000_AAAA;
      if (a == 32'h104) return 32'h0000_BBBB;
      return 32'hD000_0000 | a;
   endfunction

   // Memory model: busy for 'lat' cycles per transfer
   assign dcif.dwait = !((dcif.dREN || dcif.dWEN) && (wait_cnt >= lat));
   assign dcif.dload = written[dcif.daddr[15:2]] ? mem[dcif.daddr[15:2]] : init_word(dcif.daddr);

   always @(posedge CLK) begin
      if ((dcif.dREN || dcif.dWEN) && dcif.dwait) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard check of any memory transfer completing this cycle
   task automatic mon();
      mtx_t e;
      if (dcif.dREN || dcif.dWEN) begin
         chk("ren_wen_exclusive", 32'(dcif.dREN & dcif.dWEN), 32'd0);
         if (!dcif.dwait) begin
            if (mem_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_mem_txn: got we=%0d addr %h expected none", dcif.dWEN, dcif.daddr);
            end else begin
               e = mem_q.pop_front();
               chk("mem_we", 32'(dcif.dWEN), 32'(e.we));
               chk("mem_addr", dcif.daddr, e.addr);
               if (e.we) chk("mem_wdata", dcif.dstore, e.data);
            end
            if (dcif.dWEN) begin
               mem[dcif.daddr[15:2]]     = dcif.dstore;
               written[dcif.daddr[15:2]] = 1'b1;
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge CLK);
      mon();
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
      mtx_t t;
      t.we = we;
      t.addr = a;
      t.data = d;
      mem_q.push_back(t);
   endtask

   function automatic vec_t mk(input logic ren, input logic wen, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] ld, input logic wb,
                               input logic [31:0] wa, input logic [31:0] w0,
                               input logic [31:0] w1, input logic fill);
      vec_t v;
      v.ren = ren; v.wen = wen; v.addr = a; v.wdata = wd; v.exp_load = ld;
      v.wb = wb; v.wb_addr = wa; v.wb_d0 = w0; v.wb_d1 = w1; v.fill = fill;
      return v;
   endfunction

   task automatic access(input vec_t v);
      logic [31:0] fa;
      int   cyc;
      bit   got;
      ld_t  e;
      fa  = {v.addr[31:3], 3'b000};
      cyc = 0;
      got = 1'b0;
      if (v.wb) begin
         push_mem(1'b1, v.wb_addr, v.wb_d0);
         push_mem(1'b1, v.wb_addr + 32'd4, v.wb_d1);
      end
      if (v.fill) begin
         push_mem(1'b0, fa, 32'd0);
         push_mem(1'b0, fa + 32'd4, 32'd0);
      end
      e.chk = v.ren && !v.wen;
      e.val = v.exp_load;
      ld_q.push_back(e);
      dcif.dmemREN   = v.ren;
      dcif.dmemWEN   = v.wen;
      dcif.dmemaddr  = v.addr;
      dcif.dmemstore = v.wdata;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (dcif.dhit) begin
            got = 1'b1;
            break;
         end
         cyc++;
      end
      if (got) begin
         e = ld_q.pop_front();
         if (e.chk) chk("dmemload", dcif.dmemload, e.val);
         if (v.wb)        chk("dirty_miss_lat_ge5", 32'(cyc >= 5), 32'd1);
         else if (v.fill) chk("clean_miss_lat_ge3", 32'(cyc >= 3), 32'd1);
         else             chk("hit_latency", 32'(cyc), 32'd0);
      end else begin
         checks++;
         errors++;
         $display("FAIL dhit_timeout: addr %h got no dhit expected dhit", v.addr);
         if (ld_q.size() > 0) void'(ld_q.pop_front());
      end
      step();
      dcif.dmemREN = 1'b0;
      dcif.dmemWEN = 1'b0;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      dcif.halt = 1'b0;
      dcif.dmemREN = 1'b0;
      dcif.dmemWEN = 1'b0;
      dcif.dmemaddr = '0;
      dcif.dmemstore = '0;
      tick();
      chk("rst_dhit", 32'(dcif.dhit), 32'd0);
      chk("rst_dmemload", dcif.dmemload, 32'd0);
      chk("rst_flushed", 32'(dcif.flushed), 32'd0);
      chk("rst_dren_dwen", 32'({dcif.dREN, dcif.dWEN}), 32'd0);
      chk("rst_daddr", dcif.daddr, 32'd0);
      chk("rst_dstore", dcif.dstore, 32'd0);
      tick();
      nRST = 1'b1;
      step();
   endtask

   // Halt, wait for flushed, check the counter write timing and that flushed holds
   task automatic do_flush(input int exp_first);
      int first;
      bit done;
      first = -1;
      done  = 1'b0;
      dcif.halt = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (first < 0 && dcif.dWEN && dcif.daddr == HIT_A) first = i;
         if (dcif.flushed) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL flush_timeout: flushed=0 expected 1");
      end
      if (exp_first >= 0) chk("cnt_write_cycle", 32'(first), 32'(exp_first));
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("flushed_held", 32'(dcif.flushed), 32'd1);
         chk("halt_quiet", 32'({dcif.dhit, dcif.dREN, dcif.dWEN}), 32'd0);
      end
      chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
   endtask

   vec_t tbl[20];
   bit   seen;

   initial begin
      tbl[0]  = mk(1, 0, 32'h100, 0, 32'h0000_AAAA, 0, 0, 0, 0, 1);
      tbl[1]  = mk(1, 0, 32'h104, 0, 32'h0000_BBBB, 0, 0, 0, 0, 0);
      tbl[2]  = mk(0, 1, 32'h100, 32'h55, 0, 0, 0, 0, 0, 0);
      tbl[3]  = mk(1, 0, 32'h100, 0, 32'h55, 0, 0, 0, 0, 0);
      tbl[4]  = mk(1, 0, 32'h200, 0, 32'hD000_0200, 0, 0, 0, 0, 1);
      tbl[5]  = mk(1, 0, 32'h300, 0, 32'hD000_0300, 1, 32'h100, 32'h55, 32'h0000_BBBB, 1);
      tbl[6]  = mk(1, 0, 32'h200, 0, 32'hD000_0200, 0, 0, 0, 0, 0);
      tbl[7]  = mk(1, 0, 32'h100, 0, 32'h55, 0, 0, 0, 0, 1);
      tbl[8]  = mk(1, 0, 32'h100, 0, 32'h55, 0, 0, 0, 0, 0);
      tbl[9]  = mk(1, 0, 32'h300, 0, 32'hD000_0300, 0, 0, 0, 0, 1);
      tbl[10] = mk(1, 0, 32'h304, 0, 32'hD000_0304, 0, 0, 0, 0, 0);
      tbl[11] = mk(0, 1, 32'h10C, 32'h77, 0, 0, 0, 0, 0, 1);
      tbl[12] = mk(1, 0, 32'h10C, 0, 32'h77, 0, 0, 0, 0, 0);
      tbl[13] = mk(1, 1, 32'h10C, 32'h66, 0, 0, 0, 0, 0, 0);
      tbl[14] = mk(1, 0, 32'h10C, 0, 32'h66, 0, 0, 0, 0, 0);
      tbl[15] = mk(1, 0, 32'h100, 0, 32'h55, 0, 0, 0, 0, 1);
      tbl[16] = mk(1, 0, 32'h104, 0, 32'h0000_BBBB, 0, 0, 0, 0, 0);
      tbl[17] = mk(0, 1, 32'h100, 32'h99, 0, 0, 0, 0, 0, 0);
      tbl[18] = mk(1, 0, 32'h100, 0, 32'h99, 0, 0, 0, 0, 0);
      tbl[19] = mk(1, 0, 32'h200, 0, 32'hD000_0200, 0, 0, 0, 0, 1);

      lat = 2;
      do_reset();
      for (int i = 0; i < 15; i++) access(tbl[i]);

      // Only the set-1 block is dirty; 9 counted hits
      push_mem(1'b1, 32'h108, 32'hD000_0108);
      push_mem(1'b1, 32'h10C, 32'h66);
      push_mem(1'b1, HIT_A, 32'd9);
      do_flush(-1);

      // Reset during the second fill word
      do_reset();
      lat = 5;
      push_mem(1'b0, 32'h100, 32'd0);
      dcif.dmemREN  = 1'b1;
      dcif.dmemaddr = 32'h100;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (dcif.dREN && dcif.daddr == 32'h104) begin
            seen = 1'b1;
            break;
         end
      end
      chk("ld2_reached", 32'(seen), 32'd1);
      #1 nRST = 1'b0;
      #1 chk("rst_async_dren", 32'(dcif.dREN), 32'd0);
      dcif.dmemREN = 1'b0;
      tick();
      chk("ld1_only_done", 32'(mem_q.size()), 32'd0);
      nRST = 1'b1;
      step();
      lat = 0;
      access(mk(1, 0, 32'h100, 0, 32'h55, 0, 0, 0, 0, 1));

      // Nothing dirty: 16 skip cycles then the counter write of 0
      push_mem(1'b1, HIT_A, 32'd0);
      do_flush(17);

      do_reset();
      lat = 2;
      for (int i = 15; i < 20; i++) access(tbl[i]);
      push_mem(1'b1, 32'h100, 32'h99);
      push_mem(1'b1, 32'h104, 32'h0000_BBBB);
      push_mem(1'b1, HIT_A, 32'd3);
      do_flush(-1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
